// File: rtl/axis_channel_splitter.sv
// Broadcasts each joined real/imag AXI-Stream beat to channels 00/01/20/21 through independent
// per-output register slots. Define AXIS_SPLIT_STATS_EN to add beat_count/pkt_count counters.
module axis_channel_splitter #(
    parameter int SDATA_WIDTH   = 128,
    parameter int SSAMPLE_WIDTH = 16,
    parameter int SAMPLES       = SDATA_WIDTH / SSAMPLE_WIDTH,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [3:0]               ch_enable,
    input  logic [SDATA_WIDTH-1:0]   s_axis_real_tdata,
    input  logic                     s_axis_real_tvalid,
    input  logic                     s_axis_real_tlast,
    output logic                     s_axis_real_tready,
    input  logic [SDATA_WIDTH-1:0]   s_axis_imag_tdata,
    input  logic                     s_axis_imag_tvalid,
    input  logic                     s_axis_imag_tlast,
    output logic                     s_axis_imag_tready,
    output logic [SDATA_WIDTH-1:0]   m00_axis_real_tdata,
    output logic [SDATA_WIDTH/8-1:0] m00_axis_real_tkeep,
    output logic                     m00_axis_real_tvalid,
    output logic                     m00_axis_real_tlast,
    input  logic                     m00_axis_real_tready,
    output logic [SDATA_WIDTH-1:0]   m00_axis_imag_tdata,
    output logic [SDATA_WIDTH/8-1:0] m00_axis_imag_tkeep,
    output logic                     m00_axis_imag_tvalid,
    output logic                     m00_axis_imag_tlast,
    input  logic                     m00_axis_imag_tready,
    output logic [SDATA_WIDTH-1:0]   m01_axis_real_tdata,
    output logic [SDATA_WIDTH/8-1:0] m01_axis_real_tkeep,
    output logic                     m01_axis_real_tvalid,
    output logic                     m01_axis_real_tlast,
    input  logic                     m01_axis_real_tready,
    output logic [SDATA_WIDTH-1:0]   m01_axis_imag_tdata,
    output logic [SDATA_WIDTH/8-1:0] m01_axis_imag_tkeep,
    output logic                     m01_axis_imag_tvalid,
    output logic                     m01_axis_imag_tlast,
    input  logic                     m01_axis_imag_tready,
    output logic [SDATA_WIDTH-1:0]   m20_axis_real_tdata,
    output logic [SDATA_WIDTH/8-1:0] m20_axis_real_tkeep,
    output logic                     m20_axis_real_tvalid,
    output logic                     m20_axis_real_tlast,
    input  logic                     m20_axis_real_tready,
    output logic [SDATA_WIDTH-1:0]   m20_axis_imag_tdata,
    output logic [SDATA_WIDTH/8-1:0] m20_axis_imag_tkeep,
    output logic                     m20_axis_imag_tvalid,
    output logic                     m20_axis_imag_tlast,
    input  logic                     m20_axis_imag_tready,
    output logic [SDATA_WIDTH-1:0]   m21_axis_real_tdata,
    output logic [SDATA_WIDTH/8-1:0] m21_axis_real_tkeep,
    output logic                     m21_axis_real_tvalid,
    output logic                     m21_axis_real_tlast,
    input  logic                     m21_axis_real_tready,
    output logic [SDATA_WIDTH-1:0]   m21_axis_imag_tdata,
    output logic [SDATA_WIDTH/8-1:0] m21_axis_imag_tkeep,
    output logic                     m21_axis_imag_tvalid,
    output logic                     m21_axis_imag_tlast,
    input  logic                     m21_axis_imag_tready,
`ifdef AXIS_SPLIT_STATS_EN
    output logic [CNT_WIDTH-1:0]     beat_count,
    output logic [CNT_WIDTH-1:0]     pkt_count,
`endif
    output logic                     err_tlast_mismatch
);

    localparam int KEEP_W = SDATA_WIDTH / 8;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t                 state_reg, state_next;
    logic [3:0]             act_reg, act_next;
    logic [3:0]             load_mask;
    logic [7:0]             valid_vec, last_vec, keep_vec, tready_vec;
    logic [SDATA_WIDTH-1:0] data_vec [8];
    logic                   all_free, go;

    // Slot k = 2*channel + half (half 0 = real, 1 = imag)
    assign tready_vec = {m21_axis_imag_tready, m21_axis_real_tready,
                         m20_axis_imag_tready, m20_axis_real_tready,
                         m01_axis_imag_tready, m01_axis_real_tready,
                         m00_axis_imag_tready, m00_axis_real_tready};

    assign all_free           = &(~valid_vec | tready_vec);
    assign go                 = all_free & s_axis_real_tvalid & s_axis_imag_tvalid;
    assign s_axis_real_tready = ~reset & all_free & s_axis_imag_tvalid;
    assign s_axis_imag_tready = ~reset & all_free & s_axis_real_tvalid;

    // The first beat of a packet already uses the freshly sampled enable mask
    assign load_mask = (state_reg == IDLE) ? ch_enable : act_reg;

    always_comb begin
        state_next = state_reg;
        act_next   = act_reg;
        if (go) begin
            if (state_reg == IDLE) begin
                act_next = ch_enable;
                if (!s_axis_real_tlast) state_next = IN_PKT;
            end else if (s_axis_real_tlast) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg          <= IDLE;
            act_reg            <= 4'd0;
            err_tlast_mismatch <= 1'b0;
        end else begin
            state_reg <= state_next;
            act_reg   <= act_next;
            if (go && (s_axis_real_tlast != s_axis_imag_tlast)) err_tlast_mismatch <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            localparam int CH = gi / 2;
            logic                   valid_reg, last_reg, keep_reg;
            logic [SDATA_WIDTH-1:0] data_reg;
            logic [SDATA_WIDTH-1:0] in_data;
            logic                   in_last;

            assign in_data = (gi % 2 == 0) ? s_axis_real_tdata : s_axis_imag_tdata;
            assign in_last = (gi % 2 == 0) ? s_axis_real_tlast : s_axis_imag_tlast;

            always_ff @(posedge clock) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                    keep_reg  <= 1'b0;
                    data_reg  <= '0;
                end else if (go) begin
                    valid_reg <= load_mask[CH];
                    if (load_mask[CH]) begin
                        for (int s = 0; s < SAMPLES; s++)
                            data_reg[s*SSAMPLE_WIDTH +: SSAMPLE_WIDTH] <=
                                in_data[s*SSAMPLE_WIDTH +: SSAMPLE_WIDTH];
                        last_reg <= in_last;
                        keep_reg <= 1'b1;
                    end
                end else if (tready_vec[gi]) begin
                    valid_reg <= 1'b0;
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign last_vec[gi]  = last_reg;
            assign keep_vec[gi]  = keep_reg;
            assign data_vec[gi]  = data_reg;
        end
    endgenerate

    assign m00_axis_real_tdata  = data_vec[0];
    assign m00_axis_real_tkeep  = {KEEP_W{keep_vec[0]}};
    assign m00_axis_real_tvalid = valid_vec[0];
    assign m00_axis_real_tlast  = last_vec[0];
    assign m00_axis_imag_tdata  = data_vec[1];
    assign m00_axis_imag_tkeep  = {KEEP_W{keep_vec[1]}};
    assign m00_axis_imag_tvalid = valid_vec[1];
    assign m00_axis_imag_tlast  = last_vec[1];
    assign m01_axis_real_tdata  = data_vec[2];
    assign m01_axis_real_tkeep  = {KEEP_W{keep_vec[2]}};
    assign m01_axis_real_tvalid = valid_vec[2];
    assign m01_axis_real_tlast  = last_vec[2];
    assign m01_axis_imag_tdata  = data_vec[3];
    assign m01_axis_imag_tkeep  = {KEEP_W{keep_vec[3]}};
    assign m01_axis_imag_tvalid = valid_vec[3];
    assign m01_axis_imag_tlast  = last_vec[3];
    assign m20_axis_real_tdata  = data_vec[4];
    assign m20_axis_real_tkeep  = {KEEP_W{keep_vec[4]}};
    assign m20_axis_real_tvalid = valid_vec[4];
    assign m20_axis_real_tlast  = last_vec[4];
    assign m20_axis_imag_tdata  = data_vec[5];
    assign m20_axis_imag_tkeep  = {KEEP_W{keep_vec[5]}};
    assign m20_axis_imag_tvalid = valid_vec[5];
    assign m20_axis_imag_tlast  = last_vec[5];
    assign m21_axis_real_tdata  = data_vec[6];
    assign m21_axis_real_tkeep  = {KEEP_W{keep_vec[6]}};
    assign m21_axis_real_tvalid = valid_vec[6];
    assign m21_axis_real_tlast  = last_vec[6];
    assign m21_axis_imag_tdata  = data_vec[7];
    assign m21_axis_imag_tkeep  = {KEEP_W{keep_vec[7]}};
    assign m21_axis_imag_tvalid = valid_vec[7];
    assign m21_axis_imag_tlast  = last_vec[7];

`ifdef AXIS_SPLIT_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            beat_count <= '0;
            pkt_count  <= '0;
        end else if (go) begin
            beat_count <= beat_count + 1'b1;
            if (s_axis_real_tlast) pkt_count <= pkt_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_channel_splitter.sv
// Table-driven bench for axis_channel_splitter with a per-slot scoreboard of expected beats.
module tb_axis_channel_splitter;

    localparam int W  = 128;
    localparam int KW = W / 8;
    localparam int CW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    ch_enable;
    logic [W-1:0]  s_rdata, s_idata;
    logic          s_rvalid, s_ivalid, s_rlast, s_ilast;
    logic          s_rready, s_iready;
    logic [W-1:0]  m_data  [8];
    logic [KW-1:0] m_keep  [8];
    logic          m_valid [8];
    logic          m_last  [8];
    logic [7:0]    m_rdy;
    logic          err;
`ifdef AXIS_SPLIT_STATS_EN
    logic [CW-1:0] beat_count, pkt_count;
`endif

    always #5 clock = ~clock;

    axis_channel_splitter dut (
        .clock(clock), .reset(reset), .ch_enable(ch_enable),
        .s_axis_real_tdata(s_rdata), .s_axis_real_tvalid(s_rvalid),
        .s_axis_real_tlast(s_rlast), .s_axis_real_tready(s_rready),
        .s_axis_imag_tdata(s_idata), .s_axis_imag_tvalid(s_ivalid),
        .s_axis_imag_tlast(s_ilast), .s_axis_imag_tready(s_iready),
        .m00_axis_real_tdata(m_data[0]), .m00_axis_real_tkeep(m_keep[0]), .m00_axis_real_tvalid(m_valid[0]),
        .m00_axis_real_tlast(m_last[0]), .m00_axis_real_tready(m_rdy[0]),
        .m00_axis_imag_tdata(m_data[1]), .m00_axis_imag_tkeep(m_keep[1]), .m00_axis_imag_tvalid(m_valid[1]),
        .m00_axis_imag_tlast(m_last[1]), .m00_axis_imag_tready(m_rdy[1]),
        .m01_axis_real_tdata(m_data[2]), .m01_axis_real_tkeep(m_keep[2]), .m01_axis_real_tvalid(m_valid[2]),
        .m01_axis_real_tlast(m_last[2]), .m01_axis_real_tready(m_rdy[2]),
        .m01_axis_imag_tdata(m_data[3]), .m01_axis_imag_tkeep(m_keep[3]), .m01_axis_imag_tvalid(m_valid[3]),
        .m01_axis_imag_tlast(m_last[3]), .m01_axis_imag_tready(m_rdy[3]),
        .m20_axis_real_tdata(m_data[4]), .m20_axis_real_tkeep(m_keep[4]), .m20_axis_real_tvalid(m_valid[4]),
        .m20_axis_real_tlast(m_last[4]), .m20_axis_real_tready(m_rdy[4]),
        .m20_axis_imag_tdata(m_data[5]), .m20_axis_imag_tkeep(m_keep[5]), .m20_axis_imag_tvalid(m_valid[5]),
        .m20_axis_imag_tlast(m_last[5]), .m20_axis_imag_tready(m_rdy[5]),
        .m21_axis_real_tdata(m_data[6]), .m21_axis_real_tkeep(m_keep[6]), .m21_axis_real_tvalid(m_valid[6]),
        .m21_axis_real_tlast(m_last[6]), .m21_axis_real_tready(m_rdy[6]),
        .m21_axis_imag_tdata(m_data[7]), .m21_axis_imag_tkeep(m_keep[7]), .m21_axis_imag_tvalid(m_valid[7]),
        .m21_axis_imag_tlast(m_last[7]), .m21_axis_imag_tready(m_rdy[7]),
`ifdef AXIS_SPLIT_STATS_EN
        .beat_count(beat_count), .pkt_count(pkt_count),
`endif
        .err_tlast_mismatch(err)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    typedef struct {
        logic [3:0] en;
        logic [7:0] rdy;
        logic       vld;
        logic       rl;
        logic       il;
        int         beat;
        logic       exp_err;
    } vec_t;

    exp_t       sb [8][$];
    vec_t       vecs [$];
    int         n_checks = 0;
    int         n_err    = 0;
    logic       m_inpkt;
    logic [3:0] m_act;
    int         m_beats, m_pkts;

    function automatic logic [W-1:0] beat_real(input int b);
        logic [W-1:0] r;
        for (int s = 0; s < W / 16; s++) r[s*16 +: 16] = 16'(b * 16 + s + 1);
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act_v, input logic [W-1:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
        end
    endtask

    task automatic add(input logic [3:0] en, input logic [7:0] rdy, input logic vld,
                       input logic rl, input logic il, input int beat, input logic exp_err);
        vec_t v;
        v.en = en; v.rdy = rdy; v.vld = vld; v.rl = rl; v.il = il; v.beat = beat; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic [3:0] en, input logic [7:0] rdy, input logic vld,
                         input logic rl, input logic il, input int beat);
        ch_enable = en;
        m_rdy     = rdy;
        s_rvalid  = vld;
        s_ivalid  = vld;
        s_rlast   = rl;
        s_ilast   = il;
        s_rdata   = beat_real(beat);
        s_idata   = ~beat_real(beat);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) sb[k].delete();
        m_inpkt = 1'b0;
        m_act   = 4'd0;
        m_beats = 0;
        m_pkts  = 0;
    endtask

    // One cycle: check outputs against the scoreboard, predict acceptance, advance to next negedge
    task automatic step();
        logic       all_free, go;
        logic [3:0] mask;
        exp_t       e;
        #1;
`ifdef AXIS_SPLIT_STATS_EN
        chk("beat_count", W'(beat_count), W'(m_beats));
        chk("pkt_count", W'(pkt_count), W'(m_pkts));
`endif
        all_free = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("tvalid[%0d]", k), W'(m_valid[k]), W'(sb[k].size() != 0));
            if (sb[k].size() != 0 && !m_rdy[k]) all_free = 1'b0;
            if (m_valid[k] && m_rdy[k]) begin
                if (sb[k].size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected beat slot %0d: got %h expected none", k, m_data[k]);
                end else begin
                    e = sb[k].pop_front();
                    chk($sformatf("tdata[%0d]", k), m_data[k], e.d);
                    chk($sformatf("tlast[%0d]", k), W'(m_last[k]), W'(e.l));
                    chk($sformatf("tkeep[%0d]", k), W'(m_keep[k]), W'({KW{1'b1}}));
                end
            end
        end
        chk("s_real_tready", W'(s_rready), W'(all_free & s_ivalid));
        chk("s_imag_tready", W'(s_iready), W'(all_free & s_rvalid));
        go = all_free & s_rvalid & s_ivalid;
        if (go) begin
            mask = m_inpkt ? m_act : ch_enable;
            if (!m_inpkt) begin
                m_act   = ch_enable;
                m_inpkt = !s_rlast;
            end else if (s_rlast) begin
                m_inpkt = 1'b0;
            end
            for (int k = 0; k < 8; k++) begin
                if (mask[k / 2]) begin
                    e.d = (k % 2 == 0) ? s_rdata : s_idata;
                    e.l = (k % 2 == 0) ? s_rlast : s_ilast;
                    sb[k].push_back(e);
                end
            end
            m_beats++;
            if (s_rlast) m_pkts++;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_zero(input string tag);
        #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s tdata[%0d]", tag, k), m_data[k], '0);
            chk($sformatf("%s tkeep[%0d]", tag, k), W'(m_keep[k]), '0);
            chk($sformatf("%s tvalid[%0d]", tag, k), W'(m_valid[k]), '0);
            chk($sformatf("%s tlast[%0d]", tag, k), W'(m_last[k]), '0);
        end
        chk({tag, " s_real_tready"}, W'(s_rready), '0);
        chk({tag, " s_imag_tready"}, W'(s_iready), '0);
        chk({tag, " err"}, W'(err), '0);
`ifdef AXIS_SPLIT_STATS_EN
        chk({tag, " beat_count"}, W'(beat_count), '0);
        chk({tag, " pkt_count"}, W'(pkt_count), '0);
`endif
    endtask

    initial begin
        apply(4'hF, 8'hFF, 1'b1, 1'b0, 1'b0, 99);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_zero("reset");
        reset = 1'b0;

        // Broadcast: 4-beat packet, zero bubbles
        for (int b = 1; b <= 4; b++) add(4'hF, 8'hFF, 1'b1, b == 4, b == 4, b, 1'b0);
        add(4'hF, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        // Backpressure on m20 imag (slot 5) for 5 cycles mid-packet
        add(4'hF, 8'hFF, 1'b1, 1'b0, 1'b0, 11, 1'b0);
        add(4'hF, 8'hFF, 1'b1, 1'b0, 1'b0, 12, 1'b0);
        for (int i = 0; i < 5; i++) add(4'hF, 8'hDF, 1'b1, 1'b0, 1'b0, 13, 1'b0);
        add(4'hF, 8'hFF, 1'b1, 1'b0, 1'b0, 13, 1'b0);
        add(4'hF, 8'hFF, 1'b1, 1'b1, 1'b1, 14, 1'b0);
        // Mask latching; inactive channels' tready ignored
        add(4'h3, 8'h0F, 1'b1, 1'b0, 1'b0, 21, 1'b0);
        add(4'hF, 8'h0F, 1'b1, 1'b0, 1'b0, 22, 1'b0);
        add(4'hF, 8'h0F, 1'b1, 1'b0, 1'b0, 23, 1'b0);
        add(4'hF, 8'h0F, 1'b1, 1'b1, 1'b1, 24, 1'b0);
        add(4'hF, 8'hFF, 1'b1, 1'b0, 1'b0, 25, 1'b0);
        add(4'hF, 8'hFF, 1'b1, 1'b1, 1'b1, 26, 1'b0);
        add(4'hF, 8'h5A, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        add(4'hF, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        // No channel enabled: beat consumed and discarded
        add(4'h0, 8'hFF, 1'b1, 1'b1, 1'b1, 31, 1'b0);
        // Tlast mismatch, then a single-beat packet proving the FSM is back in IDLE
        add(4'hF, 8'hFF, 1'b1, 1'b1, 1'b0, 41, 1'b0);
        add(4'h1, 8'hFF, 1'b1, 1'b1, 1'b1, 42, 1'b1);
        add(4'hF, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 1'b1);

        foreach (vecs[i]) begin
            apply(vecs[i].en, vecs[i].rdy, vecs[i].vld, vecs[i].rl, vecs[i].il, vecs[i].beat);
            chk($sformatf("err_tlast_mismatch vec %0d", i), W'(err), W'(vecs[i].exp_err));
            step();
        end

        // Reset mid-packet with three slots full
        apply(4'h3, 8'h00, 1'b1, 1'b0, 1'b0, 51);
        step();
        apply(4'h3, 8'h01, 1'b0, 1'b0, 1'b0, 0);
        step();
        reset = 1'b1;
        apply(4'hF, 8'h00, 1'b1, 1'b0, 1'b0, 52);
        @(posedge clock);
        @(negedge clock);
        check_zero("midreset");
        reset = 1'b0;
        model_reset();
        apply(4'h4, 8'hFF, 1'b1, 1'b0, 1'b0, 52);
        step();
        apply(4'hF, 8'hFF, 1'b1, 1'b1, 1'b1, 53);
        step();
        apply(4'hF, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) step();
        for (int k = 0; k < 8; k++) chk($sformatf("drained[%0d]", k), W'(sb[k].size()), '0);

`ifdef AXIS_SPLIT_STATS_EN
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < 5; b++) begin
                apply(4'hF, 8'hFF, 1'b1, b == 4, b == 4, 60 + p * 5 + b);
                step();
            end
        apply(4'hF, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
        step();
        chk("stats beat_count", W'(beat_count), W'(15));
        chk("stats pkt_count", W'(pkt_count), W'(3));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
